mc_alu: RTL and testbench
=========================

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (legal: 8, 16, 32, 64).
REQ-002 The block SHALL have parameter SHW, default 5, giving the shift-amount width; SHW SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled with a, b, op on a rising edge while idle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-008 op  input  3  000 ADD, 001 SUB, 010 AND, 011 SLL, 100 SRL, 101 OR, 110 MUL (low WIDTH bits, unsigned), 111 DIVU.
REQ-009 busy  output  1  high while an accepted operation is in progress.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 result  output  WIDTH  result; quotient for DIVU.
REQ-012 rem  output  WIDTH  DIVU remainder; 0 for all other ops.
REQ-013 flags  output  4  {N, Z, C, V}, registered with result.
REQ-014 dz  output  1  divide-by-zero indication, registered with result.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV; busy SHALL be high exactly when the state is not IDLE or done is being driven for the current operation's completion cycle is excluded (busy low when done high).
REQ-016 start SHALL be accepted only in IDLE with busy low; start while busy SHALL be ignored with no effect on the running operation.
REQ-017 a, b, op SHALL be captured at acceptance; later input changes SHALL NOT affect the operation.
REQ-018 Single-cycle ops (ADD, SUB, AND, OR, SLL, SRL) accepted at edge k SHALL present result, flags and done=1 after edge k+1, with state remaining IDLE.
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per cycle; done SHALL pulse after edge k+WIDTH+1.
REQ-020 DIVU SHALL be restoring division, one quotient bit per cycle; done SHALL pulse after edge k+WIDTH+1.
REQ-021 DIVU with b=0 SHALL complete as a single-cycle op: result all ones, rem=a, dz=1; dz SHALL be 0 for every other completion.
REQ-022 ADD/SUB SHALL be modulo 2^WIDTH; C = carry-out for ADD, C = NOT borrow (a>=b unsigned) for SUB; V = signed two's-complement overflow.
REQ-023 C and V SHALL be 0 for AND, OR, SLL, SRL, MUL, DIVU.
REQ-024 N = result[WIDTH-1]; Z = (result == 0), for every op.
REQ-025 SLL/SRL SHALL be logical, amount b[SHW-1:0], upper bits of b ignored; shift by 0 returns a.
REQ-026 done SHALL be high for exactly one cycle per accepted operation; start in the same cycle as done high SHALL be accepted (back-to-back).
REQ-027 result, rem, flags, dz SHALL hold their last values until the next completion overwrites them.

Reset
REQ-028 reset high at a rising edge SHALL force state IDLE, busy=0, done=0, result=0, rem=0, flags=0, dz=0, and discard any partial operation.
REQ-029 reset SHALL take priority over start in the same cycle; no operation SHALL be accepted while reset is high.
REQ-030 After reset is released, the first start SHALL be accepted on the next edge with normal latency.

Verification (WIDTH=32)
REQ-031 ADD a=0x0000000F b=0x00000004 -> done one cycle after acceptance, result=0x00000013, flags=0000; SUB same operands -> 0x0000000B, C=1.
REQ-032 AND a=0x00001111 b=0x00000004 -> result=0, Z=1; SLL a=1 b=2 -> 0x00000004; ADD 0x7FFFFFFF+1 -> 0x80000000, N=1 V=1; ADD 0xFFFFFFFF+1 -> 0, Z=1 C=1.
REQ-033 MUL a=7 b=6 -> busy for 32 cycles, done at cycle 33, result=42; start pulsed mid-operation with other operands -> ignored, result still 42.
REQ-034 DIVU a=100 b=7 -> result=14, rem=2, dz=0, done at cycle 33; DIVU a=5 b=0 -> done at cycle 1, result=0xFFFFFFFF, rem=5, dz=1.
REQ-035 Reset asserted mid-MUL (cycle 10) -> next cycle busy=0, done=0, result=0; no done pulse ever for the aborted operation; subsequent ADD 2+3 -> 5.
REQ-036 Back-to-back: new start in the done cycle of ADD -> accepted, second done exactly one cycle later.

Source files
------------

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with single-cycle ADD/SUB/AND/OR/SLL/SRL,
// iterative shift-add MUL and restoring DIVU (one bit per cycle each).
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             request, sampled with a/b/op on a rising edge while idle
//   a, b, op          operands and opcode (b[SHW-1:0] is the shift amount)
//   busy              high while a multi-cycle operation is iterating
//   done              one-cycle completion pulse
//   result, rem       result (quotient for DIVU) and DIVU remainder
//   flags             {N, Z, C, V}, registered with result
//   dz                divide-by-zero indication, registered with result
module mc_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic [3:0]       flags,
  output logic             dz
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_SLL  = 3'b011,
    OP_SRL  = 3'b100, OP_OR  = 3'b101, OP_MUL = 3'b110, OP_DIVU = 3'b111
  } op_t;

  localparam int MSB = WIDTH - 1;

  state_t           r_state, w_state_nx;
  logic             r_pend;
  logic [WIDTH-1:0] r_a, r_b;
  op_t              r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [WIDTH-1:0] r_prem, r_quo;

  logic             w_accept, w_pend_multi, w_last;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_acc_nx, w_prem_nx, w_quo_nx;
  logic [WIDTH:0]   w_div_sh, w_div_tr;
  logic             w_done_nx, w_c, w_v, w_dz;
  logic [WIDTH-1:0] w_res, w_rem;

  // Operands are captured on acceptance and executed one edge later (r_pend);
  // multi-cycle ops dispatch into MUL/DIV from that pending slot.
  assign w_pend_multi = r_pend && ((r_op == OP_MUL) ||
                                   ((r_op == OP_DIVU) && (r_b != '0)));
  assign w_last       = (r_cnt == SHW'(WIDTH - 1));

  // Datapath step terms
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif     = {1'b0, r_a} - {1'b0, r_b};
  assign w_acc_nx  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Restoring division: shift next dividend bit into the partial remainder,
  // keep the trial subtraction only if it did not borrow.
  assign w_div_sh  = {r_prem, r_quo[MSB]};
  assign w_div_tr  = w_div_sh - {1'b0, r_b};
  assign w_prem_nx = w_div_tr[WIDTH] ? w_div_sh[MSB:0] : w_div_tr[MSB:0];
  assign w_quo_nx  = {r_quo[MSB-1:0], ~w_div_tr[WIDTH]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:       if (w_pend_multi) w_state_nx = (r_op == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (w_last) w_state_nx = S_IDLE;
      default:      w_state_nx = S_IDLE;
    endcase
  end

  // Output / completion logic
  always_comb begin
    busy      = (r_state != S_IDLE);
    w_accept  = start && !busy && !w_pend_multi;
    w_done_nx = 1'b0;
    w_res     = '0;
    w_rem     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_dz      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend && !w_pend_multi) begin
          w_done_nx = 1'b1;
          case (r_op)
            OP_ADD: begin
              w_res = w_sum[MSB:0];
              w_c   = w_sum[WIDTH];
              w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
              w_res = w_dif[MSB:0];
              w_c   = ~w_dif[WIDTH];
              w_v   = (r_a[MSB] != r_b[MSB]) && (w_dif[MSB] != r_a[MSB]);
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_SLL:  w_res = r_a << r_b[SHW-1:0];
            OP_SRL:  w_res = r_a >> r_b[SHW-1:0];
            OP_DIVU: begin
              // only divide-by-zero completes here
              w_res = '1;
              w_rem = r_a;
              w_dz  = 1'b1;
            end
            default: w_res = '0;
          endcase
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_done_nx = 1'b1;
          w_res     = w_acc_nx;
        end
      end
      S_DIV: begin
        if (w_last) begin
          w_done_nx = 1'b1;
          w_res     = w_quo_nx;
          w_rem     = w_prem_nx;
        end
      end
      default: w_done_nx = 1'b0;
    endcase
  end

  // Operand capture, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prem   <= '0;
      r_quo    <= '0;
      done     <= 1'b0;
      result   <= '0;
      rem      <= '0;
      flags    <= '0;
      dz       <= 1'b0;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op_t'(op);
      end
      if (w_pend_multi) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= r_a;
        r_mplier <= r_b;
        r_prem   <= '0;
        r_quo    <= r_a;
      end else if (r_state != S_IDLE) begin
        r_cnt    <= r_cnt + 1'b1;
        r_acc    <= w_acc_nx;
        r_mcand  <= {r_mcand[MSB-1:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[MSB:1]};
        r_prem   <= w_prem_nx;
        r_quo    <= w_quo_nx;
      end
      done <= w_done_nx;
      if (w_done_nx) begin
        result <= w_res;
        rem    <= w_rem;
        flags  <= {w_res[MSB], (w_res == '0), w_c, w_v};
        dz     <= w_dz;
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Testbench for mc_alu (WIDTH=32): table-driven vectors with a result
// scoreboard, plus hand sequences for the multi-cycle corner cases.
module tb_mc_alu;
  localparam int W = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, SLL = 3'd3,
                         SRL = 3'd4, OR_ = 3'd5, MUL = 3'd6, DIVU = 3'd7;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         busy, done;
  logic [W-1:0] result, rem;
  logic [3:0]   flags;
  logic         dz;

  mc_alu #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .rem(rem), .flags(flags), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic [W-1:0] rem; logic [3:0] flg; logic dz; } exp_t;
  typedef struct { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; exp_t e; int lat; } vec_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, n_done = 0;

  function automatic exp_t mk(logic [W-1:0] r, logic [W-1:0] m, logic [3:0] f, logic z);
    exp_t e;
    e.res = r; e.rem = m; e.flg = f; e.dz = z;
    return e;
  endfunction

  function automatic vec_t mkv(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y,
                               logic [W-1:0] r, logic [W-1:0] m, logic [3:0] f,
                               logic z, int lat);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.e = mk(r, m, f, z); v.lat = lat;
    return v;
  endfunction

  // Reference behaviour for the randomized section
  function automatic exp_t model(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
    exp_t       e;
    logic [W:0] t;
    logic       c, v;
    c = 1'b0; v = 1'b0; e.rem = '0; e.dz = 1'b0;
    case (o)
      ADD: begin
        t = {1'b0, x} + {1'b0, y}; e.res = t[W-1:0]; c = t[W];
        v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      SUB: begin
        e.res = x - y; c = (x >= y);
        v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      AND_: e.res = x & y;
      SLL:  e.res = x << y[4:0];
      SRL:  e.res = x >> y[4:0];
      OR_:  e.res = x | y;
      MUL:  e.res = x * y;
      default: begin
        if (y == '0) begin e.res = '1; e.rem = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.rem = x % y; end
      end
    endcase
    e.flg = {e.res[W-1], (e.res == '0), c, v};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (result=%h)", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || rem !== e.rem || flags !== e.flg || dz !== e.dz) begin
          fails++;
          $display("FAIL result: got res=%h rem=%h flags=%b dz=%b expected res=%h rem=%h flags=%b dz=%b",
                   result, rem, flags, dz, e.res, e.rem, e.flg, e.dz);
        end
      end
    end
  end

  // Issue one op, scramble inputs after acceptance, optionally pulse start
  // again at cycle poke_at, and check latency, busy length and pulse width.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e, input int lat, input int poke_at);
    int cyc, nbusy;
    bit got;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    cyc = 0; nbusy = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) nbusy++;
      if (done) got = 1;
      start = 1'b0;
      if (cyc == poke_at) begin
        start = 1'b1; op = ADD; a = 32'd100; b = 32'd100;
      end
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'(lat));
    chk("busy_cycles", 64'(nbusy), 64'(lat > 1 ? lat - 1 : 0));
    @(posedge clk); #1;
    chk("done_pulse_width", 64'(done), 64'd0);
  endtask

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    tbl[0]  = mkv(ADD,  32'h0000000F, 32'h00000004, 32'h00000013, '0, 4'b0000, 0, 1);
    tbl[1]  = mkv(SUB,  32'h0000000F, 32'h00000004, 32'h0000000B, '0, 4'b0010, 0, 1);
    tbl[2]  = mkv(AND_, 32'h00001111, 32'h00000004, 32'h00000000, '0, 4'b0100, 0, 1);
    tbl[3]  = mkv(SLL,  32'h00000001, 32'h00000002, 32'h00000004, '0, 4'b0000, 0, 1);
    tbl[4]  = mkv(ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, '0, 4'b1001, 0, 1);
    tbl[5]  = mkv(ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, '0, 4'b0110, 0, 1);
    tbl[6]  = mkv(OR_,  32'h000000F0, 32'h0000000F, 32'h000000FF, '0, 4'b0000, 0, 1);
    tbl[7]  = mkv(SRL,  32'h80000000, 32'h00000021, 32'h40000000, '0, 4'b0000, 0, 1);
    tbl[8]  = mkv(SLL,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, '0, 4'b1000, 0, 1);
    tbl[9]  = mkv(SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, '0, 4'b1000, 0, 1);
    tbl[10] = mkv(SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, '0, 4'b0011, 0, 1);
    tbl[11] = mkv(MUL,  32'h00000007, 32'h00000006, 32'h0000002A, '0, 4'b0000, 0, 33);
    tbl[12] = mkv(MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, '0, 4'b0000, 0, 33);
    tbl[13] = mkv(DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h2, 4'b0000, 0, 33);
    tbl[14] = mkv(DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h5, 4'b1000, 1, 1);
    tbl[15] = mkv(DIVU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, '0, 4'b1000, 0, 33);
    tbl[16] = mkv(DIVU, 32'h00000003, 32'h0000000A, 32'h00000000, 32'h3, 4'b0100, 0, 33);
    tbl[17] = mkv(MUL,  32'h00010000, 32'h00010000, 32'h00000000, '0, 4'b0100, 0, 33);

    // Reset state
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_rem_flags_dz", {rem, 27'd0, flags, dz}, 0);
    @(negedge clk) reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 18; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].lat, 0);

    // Back-to-back: second start issued during the first done cycle
    @(negedge clk);
    op = ADD; a = 32'd1; b = 32'd2; start = 1'b1;
    sb.push_back(mk(32'd3, '0, 4'b0000, 0));
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done1", 64'(done), 1);
    op = ADD; a = 32'd10; b = 32'd20; start = 1'b1;
    sb.push_back(mk(32'd30, '0, 4'b0000, 0));
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_gap", 64'(done), 0);
    @(posedge clk); #1;
    chk("b2b_done2", 64'(done), 1);
    @(posedge clk); #1;

    // MUL with an ignored start mid-operation, then result holds
    do_op(MUL, 32'd7, 32'd6, mk(32'd42, '0, 4'b0000, 0), 33, 10);
    repeat (5) @(posedge clk);
    #1 chk("hold_result", 64'(result), 64'd42);

    // Reset mid-MUL, with a start presented alongside the reset
    @(negedge clk);
    op = MUL; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("mul_busy_mid", 64'(busy), 1);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_result", 64'(result), 0);
    n0 = n_done;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(n_done - n0), 0);
    chk("abort_idle", 64'(busy), 0);
    do_op(ADD, 32'd2, 32'd3, mk(32'd5, '0, 4'b0000, 0), 1, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      do_op(ro, ra, rb, model(ro, ra, rb),
            (ro == MUL || (ro == DIVU && rb != '0)) ? 33 : 1, 0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
